// File: rtl/onewire_pkg.sv
// Shared constants, read-engine state type and counter sizing for the 1-Wire master engines.
package onewire_pkg;

  localparam int CLKS_PER_US  = 27;
  localparam int T_LOW_US     = 6;
  localparam int T_SAMPLE_US  = 15;
  localparam int T_RD_SLOT_US = 70;
  localparam int T_WR_SLOT_US = 70;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  // One spare bit so the terminal count never aliases to zero.
  function automatic int cnt_width(input int slot_cycles);
    return $clog2(slot_cycles) + 1;
  endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for the raw 1-Wire line; resets to the idle-high bus level.
module onewire_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/onewire_read.sv
// 1-Wire master read-byte engine: eight read slots, LSB-first assembly into data.
// Optional macro ONEWIRE_READ_MAJORITY_EN stores a 2-of-3 vote around the sample point.
module onewire_read
  import onewire_pkg::*;
#(
  parameter int CLKS_PER_US = onewire_pkg::CLKS_PER_US,
  parameter int T_LOW_US    = onewire_pkg::T_LOW_US,
  parameter int T_SAMPLE_US = onewire_pkg::T_SAMPLE_US,
  parameter int T_SLOT_US   = onewire_pkg::T_RD_SLOT_US
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bus_in,
  output logic       drive_low,
  output logic       done,
  output logic [7:0] data
);

  localparam int LOW_CYC  = T_LOW_US * CLKS_PER_US;
  localparam int SMP_CYC  = T_SAMPLE_US * CLKS_PER_US;
  localparam int SLOT_CYC = T_SLOT_US * CLKS_PER_US;
  localparam int CW       = cnt_width(SLOT_CYC);

  localparam logic [CW-1:0] LOW_C  = CW'(LOW_CYC);
  localparam logic [CW-1:0] SMP_C  = CW'(SMP_CYC);
  localparam logic [CW-1:0] LAST_C = CW'(SLOT_CYC - 1);

  if (CLKS_PER_US < 1 || !(T_LOW_US < T_SAMPLE_US) || !(T_SAMPLE_US < T_SLOT_US)) begin : g_bad_timing
    $error("onewire_read: timing parameters out of order");
  end

  rd_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            drive_low_q, drive_low_d;
  logic            bus_s;
  logic            smp_bit;

  onewire_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus_in),
    .q     (bus_s)
  );

`ifdef ONEWIRE_READ_MAJORITY_EN
  localparam logic [CW-1:0] SMP_M2_C = CW'(SMP_CYC - 2);
  localparam logic [CW-1:0] SMP_M1_C = CW'(SMP_CYC - 1);

  if (SMP_CYC < LOW_CYC + 2) begin : g_bad_majority
    $error("onewire_read: majority window overlaps the low phase");
  end

  logic early_q, early_d;
  logic late_q, late_d;

  always_comb begin
    early_d = early_q;
    late_d  = late_q;
    if (state_q == SLOT && cnt_q == SMP_M2_C) early_d = bus_s;
    if (state_q == SLOT && cnt_q == SMP_M1_C) late_d  = bus_s;
    smp_bit = (early_q & late_q) | (early_q & bus_s) | (late_q & bus_s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      early_q <= 1'b1;
      late_q  <= 1'b1;
    end else begin
      early_q <= early_d;
      late_q  <= late_d;
    end
  end
`else
  assign smp_bit = bus_s;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    done_d    = done_q;

    if (!enable) begin
      // Abort or normal release: everything but the last good byte is cleared.
      state_d   = IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
      shreg_d   = '0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!done_q) begin
            state_d   = SLOT;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end
        SLOT: begin
          if (cnt_q == SMP_C) shreg_d[bit_idx_q] = smp_bit;
          if (cnt_q == LAST_C) begin
            cnt_d     = '0;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = DONE;
              data_d  = shreg_d;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Registered pad drive, aligned with the counter value it belongs to.
    drive_low_d = (state_d == SLOT) && (cnt_d < LOW_C);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      drive_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      done_q      <= done_d;
      drive_low_q <= drive_low_d;
    end
  end

  assign drive_low = drive_low_q;
  assign done      = done_q;
  assign data      = data_q;

endmodule

// File: tb/tb_onewire_read.sv
// Bench for onewire_read: slave line model, expected-byte scoreboard and timing checks.
module tb_onewire_read;

  localparam int CPU        = 27;
  localparam int LOW_CYC    = 6 * CPU;
  localparam int SMP_CYC    = 15 * CPU;
  localparam int SLOT_CYC   = 70 * CPU;
  localparam int SLAVE_HOLD = 30 * CPU;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       bus_in = 1'b1;
  logic       drive_low;
  logic       done;
  logic [7:0] data;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;

  // Slave model state: b = bit slot in progress (-1 before the first), k = cycles since that slot's falling edge.
  int         b = -1;
  int         k = 0;
  int         glitch_bit = -1;
  logic [7:0] slave_byte = 8'hFF;
  logic       dl_prev = 1'b0;
  logic       slave_low;

  onewire_read dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bus_in    (bus_in),
    .drive_low (drive_low),
    .done      (done),
    .data      (data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (drive_low && !dl_prev) begin
      b = b + 1;
      k = 0;
    end else begin
      k = k + 1;
    end
    dl_prev = drive_low;
    slave_low = (b >= 0 && b < 8) ? (!slave_byte[b[2:0]] && k < SLAVE_HOLD) : 1'b0;
    // A one-cycle dip landing on the DUT's sample edge (the synchronizer delays it by two).
    bus_in = !(drive_low || slave_low || (glitch_bit >= 0 && b == glitch_bit && k == SMP_CYC - 2));
  end

  logic done_prev = 1'b0;
  int   low_run = 0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: data %0h with no byte outstanding", data);
      end else begin
        chk("data", data, exp_q.pop_front());
      end
    end
    done_prev = done;
    if (drive_low) begin
      low_run++;
    end else begin
      if (low_run > 0 && enable && rst_n) chk("low_phase", low_run, LOW_CYC);
      low_run = 0;
    end
  end

  task automatic read_byte(input logic [7:0] val, input int g_bit, input logic [7:0] exp);
    int t0, t1;
    slave_byte = val;
    glitch_bit = g_bit;
    b = -1;
    exp_q.push_back(exp);
    enable = 1'b1;
    t0 = -1;
    t1 = -1;
    for (int t = 1; t <= 20000 && t1 < 0; t++) begin
      @(negedge clk);
      if (drive_low && t0 < 0) t0 = t;
      if (done) t1 = t;
    end
    chk("start_latency", t0, 1);
    // done seen on the 15121st cycle counting the first drive_low cycle as cycle 1
    chk("byte_latency", t1 - t0 + 1, 8 * SLOT_CYC + 1);
    last_data = exp;
    glitch_bit = -1;
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    @(negedge clk);
    chk("done_fall", done, 0);
    chk("drop_drive", drive_low, 0);
    chk("drop_data", data, last_data);
  endtask

  task automatic wait_slot_pos(input int bit_no, input int cyc, input string name);
    int found;
    found = 0;
    for (int t = 0; t < 20000 && found == 0; t++) begin
      @(negedge clk);
      if (b == bit_no && k == cyc) found = 1;
    end
    chk(name, found, 1);
  endtask

  initial begin
    int         nlow, nbad;
    logic [7:0] v;

    repeat (4) @(negedge clk);
    chk("rst_drive", drive_low, 0);
    chk("rst_done", done, 0);
    chk("rst_data", data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    read_byte(8'hA5, -1, 8'hA5);
    drop_enable();
    read_byte(8'h00, -1, 8'h00);
    drop_enable();
    read_byte(8'hFF, -1, 8'hFF);

    nlow = 0;
    nbad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (drive_low) nlow++;
      if (!done || data !== 8'hFF) nbad++;
    end
    chk("hold_no_pulse", nlow, 0);
    chk("hold_stable", nbad, 0);
    drop_enable();

    // Abort during bit 3's low phase, then a fresh full byte with a glitch on released bit 2.
    slave_byte = 8'h3C;
    b = -1;
    enable = 1'b1;
    wait_slot_pos(3, 100, "abort_reach");
    enable = 1'b0;
    @(negedge clk);
    chk("abort_drive", drive_low, 0);
    chk("abort_done", done, 0);
    chk("abort_data", data, last_data);
    @(negedge clk);

    v = 8'($urandom) | 8'h04;
`ifdef ONEWIRE_READ_MAJORITY_EN
    read_byte(v, 2, v);
`else
    read_byte(v, 2, v & 8'hFB);
`endif
    drop_enable();

    // Synchronous reset mid-slot with enable still high.
    slave_byte = 8'($urandom);
    b = -1;
    enable = 1'b1;
    wait_slot_pos(5, 1000, "reset_reach");
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_drive", drive_low, 0);
    chk("midrst_done", done, 0);
    chk("midrst_data", data, 8'h00);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_data = 8'h00;
    @(negedge clk);
    chk("post_rst_idle", drive_low, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
